pipelined_shifter_operand: RTL

- Pipelined, parametrised successor to the combinational shifter/extender.
- Produces the data-processing shifter operand and its carry, and the load/store offset.
- Adds shift-by-register, the ARM special amount-0 encodings (LSR/ASR #32, RRX) and correct carry for every mode.
- Sits between register-file read and ALU in the EX stage; uses a valid/ready handshake with 2-cycle latency and throughput of 1 per cycle.

---
 rtl/shifter_pkg.sv | 28 ++
 rtl/shift_core.sv | 69 ++++++
 rtl/pipelined_shifter_operand.sv | 133 +++++++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// Shared encodings and the stage-1 payload for the pipelined shifter operand unit.
// The datapath-width fields live in the top level so the package stays width-agnostic.
package shifter_pkg;

    typedef enum logic [2:0] {
        SOP_IMM_SHIFT = 3'b000,
        SOP_ROT_IMM   = 3'b001,
        SOP_IMM_OFF   = 3'b010,
        SOP_REG_OFF   = 3'b011,
        SOP_REG_SHIFT = 3'b100
    } sop_e;

    typedef enum logic [1:0] {
        ST_LSL = 2'b00,
        ST_LSR = 2'b01,
        ST_ASR = 2'b10,
        ST_ROR = 2'b11
    } st_e;

    // Decoded control carried from stage 1 into the shift core.
    typedef struct packed {
        st_e  typ;
        logic rrx;
        logic carry;
        logic err;
    } s1_ctrl_t;

endpackage

// File: rtl/shift_core.sv
// Combinational barrel shifter with ARM carry semantics for LSL/LSR/ASR/ROR/RRX.
// An amount of zero (without RRX) passes data and carry_in through unchanged.
module shift_core
    import shifter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_W    = 8
) (
    input  logic [DATA_W-1:0] data,
    input  logic [N_W-1:0]    n,
    input  st_e               typ,
    input  logic              rrx,
    input  logic              carry_in,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    localparam int              LOG_W = $clog2(DATA_W);
    localparam logic [N_W-1:0]  W_N   = N_W'(DATA_W);

    logic [LOG_W-1:0]         r;
    logic [DATA_W:0]          lsl_w;
    logic [DATA_W:0]          lsr_w;
    logic signed [DATA_W:0]   asr_w;
    logic [DATA_W-1:0]        ror_v;

    // One guard bit beside the data makes the shifted-out bit fall out as the carry.
    assign r     = n[LOG_W-1:0];
    assign lsl_w = {1'b0, data} << n;
    assign lsr_w = {data, 1'b0} >> n;
    assign asr_w = $signed({data, 1'b0}) >>> n;
    assign ror_v = (data >> r) | (data << (DATA_W - int'(r)));

    always_comb begin
        // NOTE: both outputs get a default first, so no path through the case can infer a latch.
        result = data;
        carry  = carry_in;
        if (rrx) begin
            result = {carry_in, data[DATA_W-1:1]};
            carry  = data[0];
        end else if (n != '0) begin
            case (typ)
                ST_LSL: begin
                    result = lsl_w[DATA_W-1:0];
                    carry  = lsl_w[DATA_W];
                end
                ST_LSR: begin
                    result = lsr_w[DATA_W:1];
                    carry  = lsr_w[0];
                end
                ST_ASR: begin
                    if (n >= W_N) begin
                        result = {DATA_W{data[DATA_W-1]}};
                        carry  = data[DATA_W-1];
                    end else begin
                        result = asr_w[DATA_W:1];
                        carry  = asr_w[0];
                    end
                end
                default: begin
                    // A multiple of W rotates back to the input, so MSB is the carry either way.
                    result = ror_v;
                    carry  = ror_v[DATA_W-1];
                end
            endcase
        end
    end

endmodule

// File: rtl/pipelined_shifter_operand.sv
// Two-stage shifter-operand / offset generator: stage 1 decodes the amount, stage 2 shifts.
// Valid/ready handshake with one request per cycle and a skid-free stall path.
module pipelined_shifter_operand
    import shifter_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int RS_AMT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          shifter_op,
    input  logic [1:0]          shift_type,
    input  logic [DATA_W-1:0]   operand_a,
    input  logic [RS_AMT_W-1:0] shift_reg,
    input  logic [11:0]         imm_field,
    input  logic                carry_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   shift_result,
    output logic                carry_out,
    output logic                op_err
);

    localparam int LOG_W = $clog2(DATA_W);
    localparam int N_W   = (RS_AMT_W > LOG_W + 1) ? RS_AMT_W : LOG_W + 1;

    logic              s1_v;
    logic              s2_v;
    logic              s2_adv;
    logic              accept;
    s1_ctrl_t          d_ctrl;
    s1_ctrl_t          s1_ctrl;
    logic [DATA_W-1:0] d_data;
    logic [DATA_W-1:0] s1_data;
    logic [N_W-1:0]    d_n;
    logic [N_W-1:0]    s1_n;
    logic [DATA_W-1:0] core_result;
    logic              core_carry;

    assign s2_adv    = !s2_v || out_ready;
    assign in_ready  = !s1_v || s2_adv;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_v;

    // Offsets and reserved ops are steered through the core as a zero-amount LSL.
    always_comb begin
        d_ctrl = '{typ: ST_LSL, rrx: 1'b0, carry: carry_in, err: 1'b0};
        d_data = operand_a;
        d_n    = '0;
        case (shifter_op)
            SOP_IMM_SHIFT: begin
                d_ctrl.typ = st_e'(shift_type);
                d_n        = N_W'(imm_field[11:7]);
                if (imm_field[11:7] == 5'd0) begin
                    case (shift_type)
                        ST_LSR, ST_ASR: d_n = N_W'(DATA_W);
                        ST_ROR:         d_ctrl.rrx = 1'b1;
                        default:        d_n = '0;
                    endcase
                end
            end
            SOP_ROT_IMM: begin
                d_ctrl.typ = ST_ROR;
                d_data     = DATA_W'(imm_field[7:0]);
                d_n        = N_W'({imm_field[11:8], 1'b0});
            end
            SOP_IMM_OFF: begin
                d_data = DATA_W'(imm_field);
            end
            SOP_REG_OFF: begin
                d_data = operand_a;
            end
            SOP_REG_SHIFT: begin
                d_ctrl.typ = st_e'(shift_type);
                d_n        = N_W'(shift_reg);
            end
            default: begin
                d_data     = '0;
                d_ctrl.err = 1'b1;
            end
        endcase
    end

    // NOTE: payload registers carry no reset; only the valid bits decide what is observable.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_ctrl <= d_ctrl;
            s1_data <= d_data;
            s1_n    <= d_n;
        end
    end

    shift_core #(
        .DATA_W (DATA_W),
        .N_W    (N_W)
    ) u_shift_core (
        .data     (s1_data),
        .n        (s1_n),
        .typ      (s1_ctrl.typ),
        .rrx      (s1_ctrl.rrx),
        .carry_in (s1_ctrl.carry),
        .result   (core_result),
        .carry    (core_carry)
    );

    // NOTE: non-blocking assignments keep every stage sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v         <= 1'b0;
            s2_v         <= 1'b0;
            shift_result <= '0;
            carry_out    <= 1'b0;
            op_err       <= 1'b0;
        end else begin
            if (accept) begin
                s1_v <= 1'b1;
            end else if (s2_adv) begin
                s1_v <= 1'b0;
            end
            if (s2_adv) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    shift_result <= core_result;
                    carry_out    <= core_carry;
                    op_err       <= s1_ctrl.err;
                end
            end
        end
    end

endmodule
